// File: rtl/clk_div_bank.sv
// clk_div_bank -- multi-channel clock-enable / divider bank.
//
// Every channel counts system clock edges against its own runtime-programmable
// divisor.  It produces a registered square wave (clk_out) and a registered
// one-cycle pulse (tick) once per period.  A channel runs either free or as a
// one-shot that stops after its first period and raises a sticky done flag.
//
// Divisor writes go to a per-channel pending register.  The pending value is
// copied into the active divisor only at a safe point, so the running period
// always completes with the old divisor.  The safe points are:
//   - the edge where the channel wraps,
//   - any edge where the channel is not running,
//   - a sync_clr.
//
// Handshake: div_wr is a single-cycle strobe with no back-pressure.  Every
// write is answered one cycle later by exactly one pulse: div_ack if the write
// was accepted, or div_err if it was rejected.  No pulse is issued for a write
// that arrives in a reset cycle.
//
// Ports
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous reset, active-low
//   en        in   NUM_CH  per-channel run enable (dropping it re-arms the channel)
//   oneshot   in   NUM_CH  per-channel mode: 0 free-run, 1 one-shot
//   sync_clr  in   1       phase-align all channels and apply pending divisors
//   div_wr    in   1       divisor write strobe
//   div_ch    in   CH_W    write target channel
//   div_val   in   CNT_W   new divisor (accepted when >= 2)
//   div_ack   out  1       write accepted (one cycle after div_wr)
//   div_err   out  1       write rejected (one cycle after div_wr)
//   clk_out   out  NUM_CH  square wave: high floor(div/2) cycles, low ceil(div/2) cycles
//   tick      out  NUM_CH  one-cycle pulse per period
//   done      out  NUM_CH  sticky one-shot completion flag
module clk_div_bank #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 24,
    parameter int DEFAULT_DIV = 50000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] oneshot,
    input  logic              sync_clr,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_ack,
    output logic              div_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] done
);

    logic [CNT_W-1:0]  cnt_q     [NUM_CH];
    logic [CNT_W-1:0]  cnt_d     [NUM_CH];
    logic [CNT_W-1:0]  div_act_q [NUM_CH];
    logic [CNT_W-1:0]  div_act_d [NUM_CH];
    logic [CNT_W-1:0]  pend_q    [NUM_CH];
    logic [CNT_W-1:0]  pend_d    [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt   [NUM_CH];
    logic [NUM_CH-1:0] pend_v_q, pend_v_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] running, wrap, apply;
    logic              div_ack_q, div_ack_d;
    logic              div_err_q, div_err_d;
    logic              wr_ok;

    // Write validation: the channel index may be out of range when NUM_CH
    // is not a power of two.
    always_comb begin
        wr_ok     = div_wr && (div_val >= CNT_W'(2))
                    && ({1'b0, div_ch} < (CH_W+1)'(NUM_CH));
        div_ack_d = wr_ok;
        div_err_d = div_wr && !wr_ok;
    end

    // Per-channel status.  A one-shot channel that is done counts as
    // stopped even while its enable is still high.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            running[i] = en[i] && !(oneshot[i] && done_q[i]);
            wrap[i]    = (cnt_q[i] == div_act_q[i] - CNT_W'(1));
            cnt_nxt[i] = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
            apply[i]   = pend_v_q[i] && (sync_clr || !running[i] || wrap[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            div_act_d[i] = div_act_q[i];
            pend_d[i]    = pend_q[i];
            pend_v_d[i]  = pend_v_q[i];
            clk_out_d[i] = 1'b0;
            tick_d[i]    = 1'b0;
            done_d[i]    = done_q[i];

            if (sync_clr) begin
                cnt_d[i]  = '0;
                done_d[i] = 1'b0;
            end else if (!en[i]) begin
                cnt_d[i]  = '0;
                done_d[i] = 1'b0;
            end else if (running[i]) begin
                cnt_d[i]     = cnt_nxt[i];
                tick_d[i]    = wrap[i];
                clk_out_d[i] = (cnt_nxt[i] < (div_act_q[i] >> 1));
                if (wrap[i] && oneshot[i]) begin
                    done_d[i] = 1'b1;
                end
            end

            // The old pending value is applied first, so a write landing on
            // an apply edge becomes the next pending value rather than being lost.
            if (apply[i]) begin
                div_act_d[i] = pend_q[i];
                pend_v_d[i]  = 1'b0;
            end
            if (wr_ok && (div_ch == CH_W'(i))) begin
                pend_d[i]   = div_val;
                pend_v_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= '0;
                div_act_q[i] <= CNT_W'(DEFAULT_DIV);
                pend_q[i]    <= '0;
            end
            pend_v_q  <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
            done_q    <= '0;
            div_ack_q <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]     <= cnt_d[i];
                div_act_q[i] <= div_act_d[i];
                pend_q[i]    <= pend_d[i];
            end
            pend_v_q  <= pend_v_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            div_ack_q <= div_ack_d;
            div_err_q <= div_err_d;
        end
    end

    assign div_ack = div_ack_q;
    assign div_err = div_err_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign done    = done_q;

endmodule
